// File: rtl/seq_alu_pkg.sv
// Shared types for the registered ALU: opcode and FSM encodings plus the
// result-flag bundle.
package seq_alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_NOT = 3'b101,
      OP_SHL = 3'b110,
      OP_MUL = 3'b111
   } op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_e;

   typedef struct packed {
      logic carry;
      logic zero;
      logic neg;
      logic ovf;
   } flags_t;

endpackage

// File: rtl/seq_alu_mul.sv
// Unsigned shift-add multiplier: one bit of b per cycle over WIDTH cycles.
// done and product are combinational during the final step.
module seq_alu_mul #(
   parameter int unsigned WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   logic [CW-1:0]        cnt_q;
   logic [WIDTH-1:0]     mcand_q;
   logic [2*WIDTH-1:0]   prod_q;
   logic [2*WIDTH-1:0]   prod_d;
   logic [WIDTH:0]       sum;

   // Upper half accumulates the multiplicand; lower half holds the unused
   // multiplier bits and shifts right as product bits fill in from the top.
   always_comb begin
      sum    = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
      prod_d = {sum, prod_q[WIDTH-1:1]};
   end

   assign done    = (cnt_q == CW'(1));
   assign product = prod_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         mcand_q <= '0;
         prod_q  <= '0;
      end else if (start) begin
         cnt_q   <= CW'(WIDTH);
         mcand_q <= a;
         prod_q  <= {{WIDTH{1'b0}}, b};
      end else if (cnt_q != '0) begin
         cnt_q   <= cnt_q - CW'(1);
         prod_q  <= prod_d;
      end
   end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready handshake, accumulator chaining and a
// multi-cycle multiply; results and flags are held until consumed.
module seq_alu
   import seq_alu_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [2:0]         op,
   input  logic               use_acc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   y,
   output logic [WIDTH-1:0]   y_hi,
   output logic               carry,
   output logic               zero,
   output logic               neg,
   output logic               ovf
);

   state_e               state_q;
   logic [WIDTH-1:0]     acc_q;
   logic [WIDTH-1:0]     y_q;
   logic [WIDTH-1:0]     y_hi_q;
   flags_t               flags_q;
   logic                 out_valid_q;

   op_e                  op_in;
   logic [WIDTH-1:0]     a_eff;
   logic [WIDTH:0]       wide;
   logic [WIDTH-1:0]     res;
   logic                 res_c;
   logic                 res_v;
   logic [WIDTH-1:0]     y_d;
   logic [WIDTH-1:0]     y_hi_d;
   flags_t               flags_d;
   logic                 accept;
   logic                 mul_start;
   logic                 mul_done;
   logic                 load;
   logic [2*WIDTH-1:0]   product;

   assign op_in     = op_e'(op);
   assign a_eff     = use_acc ? acc_q : a;
   assign in_ready  = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
   assign accept    = in_valid && in_ready;
   assign mul_start = accept && (op_in == OP_MUL);
   assign load      = (accept && (op_in != OP_MUL)) || ((state_q == ST_MUL) && mul_done);

   seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (mul_start),
      .a       (a_eff),
      .b       (b),
      .done    (mul_done),
      .product (product)
   );

   always_comb begin
      wide  = '0;
      res   = '0;
      res_c = 1'b0;
      res_v = 1'b0;
      case (op_in)
         OP_ADD: begin
            wide  = {1'b0, a_eff} + {1'b0, b};
            res   = wide[WIDTH-1:0];
            res_c = wide[WIDTH];
            res_v = (a_eff[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a_eff[WIDTH-1]);
         end
         OP_SUB: begin
            wide  = {1'b0, a_eff} - {1'b0, b};
            res   = wide[WIDTH-1:0];
            res_c = wide[WIDTH];
            res_v = (a_eff[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a_eff[WIDTH-1]);
         end
         OP_AND:  res = a_eff & b;
         OP_OR:   res = a_eff | b;
         OP_XOR:  res = a_eff ^ b;
         OP_NOT:  res = ~a_eff;
         OP_SHL: begin
            res   = {a_eff[WIDTH-2:0], 1'b0};
            res_c = a_eff[WIDTH-1];
         end
         default: res = '0;
      endcase
   end

   // While in ST_MUL the only possible load is the multiplier's final step.
   always_comb begin
      flags_d = '0;
      if (state_q == ST_MUL) begin
         y_d           = product[WIDTH-1:0];
         y_hi_d        = product[2*WIDTH-1:WIDTH];
         flags_d.carry = |y_hi_d;
      end else begin
         y_d           = res;
         y_hi_d        = '0;
         flags_d.carry = res_c;
         flags_d.ovf   = res_v;
      end
      flags_d.zero = (y_d == '0);
      flags_d.neg  = y_d[WIDTH-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         acc_q       <= '0;
         y_q         <= '0;
         y_hi_q      <= '0;
         flags_q     <= '0;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: if (mul_start) state_q <= ST_MUL;
            ST_MUL:  if (mul_done)  state_q <= ST_IDLE;
         endcase
         if (load) begin
            y_q         <= y_d;
            y_hi_q      <= y_hi_d;
            flags_q     <= flags_d;
            acc_q       <= y_d;
            out_valid_q <= 1'b1;
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign y         = y_q;
   assign y_hi      = y_hi_q;
   assign carry     = flags_q.carry;
   assign zero      = flags_q.zero;
   assign neg       = flags_q.neg;
   assign ovf       = flags_q.ovf;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: the driver pushes model results on acceptance,
// a monitor pops and compares on every consumed result.
module tb_seq_alu;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [7:0]   a;
   logic [7:0]   b;
   logic [2:0]   op;
   logic         use_acc;
   logic         out_valid;
   logic         out_ready;
   logic [7:0]   y;
   logic [7:0]   y_hi;
   logic         carry;
   logic         zero;
   logic         neg;
   logic         ovf;

   seq_alu #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .use_acc   (use_acc),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
      .y_hi      (y_hi),
      .carry     (carry),
      .zero      (zero),
      .neg       (neg),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] y;
      logic [7:0] yh;
      logic       c;
      logic       z;
      logic       n;
      logic       v;
   } exp_t;

   exp_t sb_q[$];
   int   errors  = 0;
   int   checks  = 0;
   int   acc_m   = 0;
   int   or_mode = 1;   // 0: random out_ready, 1: always ready, 2: stalled

   function automatic exp_t model(int opc, int av, int bv);
      exp_t e;
      int r, sa, sb, ss;
      sa = (av >= 128) ? av - 256 : av;
      sb = (bv >= 128) ? bv - 256 : bv;
      e.yh = 8'h00;
      e.c  = 1'b0;
      e.v  = 1'b0;
      r    = 0;
      case (opc)
         0: begin r = av + bv; e.c = (r > 255); ss = sa + sb; e.v = (ss > 127) || (ss < -128); end
         1: begin r = av - bv + 256; e.c = (av < bv); ss = sa - sb; e.v = (ss > 127) || (ss < -128); end
         2: r = av & bv;
         3: r = av | bv;
         4: r = av ^ bv;
         5: r = 255 - av;
         6: begin r = av * 2; e.c = (av >= 128); end
         default: begin r = av * bv; e.yh = 8'(r / 256); e.c = ((r / 256) != 0); end
      endcase
      e.y = 8'(r % 256);
      e.z = (e.y == 8'h00);
      e.n = (e.y >= 8'h80);
      return e;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic send(input int opc, input int av, input int bv, input bit ua);
      int   waitc;
      exp_t e;
      @(negedge clk);
      in_valid = 1'b1;
      op       = 3'(opc);
      a        = 8'(av);
      b        = 8'(bv);
      use_acc  = ua;
      waitc    = 0;
      while (!in_ready && waitc < 200) begin
         @(negedge clk);
         waitc++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: in_ready=%b expected 1 within 200 cycles", in_ready);
      end else begin
         e     = model(opc, ua ? acc_m : av, bv);
         acc_m = e.y;
         sb_q.push_back(e);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst      = 1'b1;
      in_valid = 1'b0;
      sb_q.delete();
      acc_m    = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("drain", sb_q.size(), 0);
   endtask

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (or_mode)
            1:       out_ready = 1'b1;
            2:       out_ready = 1'b0;
            default: out_ready = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && out_valid && out_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_result: got y=%h y_hi=%h with nothing outstanding", y, y_hi);
            end else begin
               e = sb_q.pop_front();
               if ({y, y_hi, carry, zero, neg, ovf} !== {e.y, e.yh, e.c, e.z, e.n, e.v}) begin
                  errors++;
                  $display("FAIL result: got y=%h y_hi=%h c=%b z=%b n=%b v=%b expected y=%h y_hi=%h c=%b z=%b n=%b v=%b",
                           y, y_hi, carry, zero, neg, ovf, e.y, e.yh, e.c, e.z, e.n, e.v);
               end
            end
         end
      end
   end

   initial begin
      #1_000_000;
      errors++;
      $display("FAIL watchdog: simulation did not complete in time");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      int   bad;
      logic [7:0] y0;
      logic [3:0] f0;
      bit   bp_done;
      int   n;

      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0; use_acc = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      @(negedge clk);
      check("reset_out_valid", out_valid, 0);
      check("reset_in_ready", in_ready, 1);
      check("reset_y", {y_hi, y}, 0);
      check("reset_flags", {carry, zero, neg, ovf}, 0);

      or_mode = 1;
      for (int i = 0; i < 7; i++) send(i, 'h0C, 'h05, 1'b0);
      send(1, 'h05, 'h0C, 1'b0);
      send(0, 'h7F, 'h01, 1'b0);
      send(0, 'hFF, 'h01, 1'b0);
      wait_drain();

      send(7, 'h0C, 'h05, 1'b0);
      bad = 0;
      for (int k = 0; k < int'(W); k++) begin
         @(negedge clk);
         if (out_valid || in_ready) bad++;
      end
      @(negedge clk);
      if (!out_valid) bad++;
      check("mul_latency", bad, 0);
      send(7, 'hFF, 'hFF, 1'b0);
      wait_drain();

      do_reset();
      for (int i = 0; i < 3; i++) send(0, 'h00, 'h03, 1'b1);
      wait_drain();

      or_mode = 2;
      @(posedge clk);
      #2;
      send(0, 'h21, 'h13, 1'b0);
      bp_done = 1'b0;
      fork
         begin
            send(0, 'h00, 'h01, 1'b1);
            bp_done = 1'b1;
         end
      join_none
      @(negedge clk);
      y0 = y;
      f0 = {carry, zero, neg, ovf};
      check("bp_first_valid", out_valid, 1);
      bad = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (!out_valid || y !== y0 || {carry, zero, neg, ovf} !== f0 || in_ready) bad++;
      end
      check("backpressure_hold", bad, 0);
      or_mode = 1;
      @(posedge clk);
      #2;
      @(negedge clk);
      check("consume_and_accept", {out_valid, out_ready, in_ready}, 3'b111);
      n = 0;
      while (!bp_done && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("bp_send_done", bp_done, 1);
      wait_drain();

      send(7, 'h0C, 'h05, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      sb_q.delete();
      acc_m = 0;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("abort_out_valid", out_valid, 0);
      check("abort_in_ready", in_ready, 1);
      bad = 0;
      for (int k = 0; k < int'(W) + 2; k++) begin
         @(negedge clk);
         if (out_valid) bad++;
      end
      check("abort_no_partial", bad, 0);
      send(0, 'h00, 'h00, 1'b1);
      send(0, 'h01, 'h01, 1'b0);
      wait_drain();

      or_mode = 0;
      for (int i = 0; i < 400; i++) begin
         int av, bv;
         av = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) * 85 : int'($urandom_range(0, 255));
         bv = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) * 85 : int'($urandom_range(0, 255));
         if ($urandom_range(0, 7) == 0) @(negedge clk);
         send(int'($urandom_range(0, 7)), av, bv, 1'($urandom_range(0, 1)));
      end
      or_mode = 1;
      wait_drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, registered successor to the 8-bit combinational ALU. It accepts WIDTH-bit operands and a 3-bit opcode over a valid/ready handshake and returns a registered result with carry, zero, negative and overflow flags. It adds an accumulator-chaining mode and a multi-cycle shift-add multiply. It sits between an operand source (sequencer or test driver) and a result consumer that may stall.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand/opcode presented
- in_ready  out  1  block accepts operands this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- op  in  3  opcode
- use_acc  in  1  1: accumulator replaces operand A
- out_valid  out  1  result registers hold an unconsumed result
- out_ready  in  1  consumer takes result this cycle
- y  out  WIDTH  result (low word for MUL)
- y_hi  out  WIDTH  MUL high word; 0 for all other ops
- carry, zero, neg, ovf  out  1 each  result flags

## Operation
- Opcodes: 000 ADD a+b; 001 SUB a−b; 010 AND; 011 OR; 100 XOR; 101 NOT a; 110 SHL a by 1; 111 MUL, unsigned a×b, 2·WIDTH-bit product.
- Effective A = acc if use_acc else a. Sampled at acceptance.
- Accumulator acc (WIDTH bits, reset 0) loads y at the same edge as every result load into the output registers.
- Flags:
  - carry: ADD carry-out; SUB borrow (1 iff A<b unsigned); SHL bit shifted out; MUL (y_hi≠0); all other ops 0.
  - zero: y==0 (low word only).
  - neg: y[WIDTH−1].
  - ovf: signed overflow for ADD/SUB; 0 otherwise.
- FSM states:
  - IDLE: accept when in_valid && in_ready. Non-MUL ops stay in IDLE; MUL goes to MUL.
  - MUL: shift-add loop, one bit of b per cycle, WIDTH cycles. On the last cycle, load the product into y/y_hi/flags and return to IDLE.
- in_ready = (state==IDLE) && (!out_valid || out_ready). in_ready is 0 throughout MUL.
- Output registers hold stable while out_valid && !out_ready. A result is consumed on out_valid && out_ready.
- When a consume and a new load occur in the same cycle, out_valid stays 1 and takes the new result.
- Reset values: state IDLE; acc 0; out_valid 0; y 0; y_hi 0; all flags 0. in_ready is 1 in the first cycle after reset.

## Timing
- Non-MUL: accept at edge N → out_valid=1 with result from edge N. Latency 1. Throughput 1/cycle when out_ready is held high.
- MUL: accept at edge N → result valid from edge N+WIDTH. in_ready=0 for cycles N+1 … N+WIDTH.
- A MUL that completes while a previous result is unconsumed cannot occur: MUL is accepted only when the output registers are free or being drained.
- Back-to-back use_acc ops see the acc value loaded at the preceding result edge.
- rst mid-MUL aborts the operation: next cycle is IDLE, out_valid=0, acc=0, and no partial result is ever emitted.
- rst overrides any simultaneous handshake.

## Structure
- Package seq_alu_pkg:
  - op_e enum (ADD, SUB, AND, OR, XOR, NOT, SHL, MUL with the codes above).
  - state_e enum (IDLE, MUL).
  - Flag-bundle struct.
- Sub-module seq_alu_mul: WIDTH-parametrised shift-add multiplier.
  - Ports: start, a, b → done, product[2·WIDTH].
  - Contains the bit counter; sized $clog2(WIDTH+1).
- Top: handshake, FSM, combinational single-cycle datapath, flag generation, output/acc registers.

## Test plan
- WIDTH=8, a=0x0C, b=0x05, sweep op 000–110 with out_ready=1 → y=0x11, 0x07, 0x04, 0x0D, 0x09, 0xF3, 0x18 on consecutive cycles. All flags 0 except neg=1 for NOT.
- SUB a=0x05, b=0x0C → y=0xF9, carry=1, neg=1, ovf=0. ADD a=0x7F, b=0x01 → y=0x80, ovf=1, neg=1, carry=0. ADD 0xFF+0x01 → y=0x00, carry=1, zero=1.
- MUL a=0x0C, b=0x05 → out_valid exactly 8 cycles after acceptance, y=0x3C, y_hi=0x00, carry=0, with in_ready=0 meanwhile. MUL 0xFF×0xFF → y=0x01, y_hi=0xFE, carry=1.
- Accumulator chain: use_acc=1, ADD b=0x03 three times from reset → y=0x03, 0x06, 0x09 back-to-back.
- Backpressure: hold out_ready=0 for 5 cycles after an ADD result → y/flags stable, in_ready=0, no new acceptance. Release → consume and accept in the same cycle.
- Reset mid-MUL at cycle 4 of 8 → next cycle out_valid=0, in_ready=1, acc=0. Next ADD 0x01+0x01 → y=0x02.
